// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clears the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// The head entry is read straight from storage registers.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem request FSM and fetch buffer.
// Optional perf counters (perf_fetched/perf_flushed) under IFU_PERF_CNT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [XLEN-1:0]     id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [XLEN-1:0]     id_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            push;
  logic            pop;
  logic            granted;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    din;

  assign pop  = id_valid && id_ready;
  assign din  = '{instr: imem_rdata, pc: req_pc_q};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign id_valid  = !empty;
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign id_opcode = head.instr[OPCODE_W-1:0];
  assign imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    granted  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && !full) state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          state_d = imem_gnt ? DRAIN : IDLE;
        end else if (imem_gnt) begin
          state_d = WAIT;
          granted = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (granted) req_pc_q <= pc_q;
      if (redirect_valid)  pc_q <= align_pc(redirect_pc);
      else if (granted)    pc_q <= pc_q + XLEN'(4);
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic in_flight;

  // A word granted this cycle or awaited in WAIT is lost when redirected;
  // the head popped in the redirect cycle still reaches decode.
  assign in_flight = (state_q == REQ && imem_gnt) || (state_q == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid)
        perf_flushed <= perf_flushed + 32'(count) - 32'(pop) + 32'(in_flight);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/redirect/reset cases.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int errors = 0;
  int checks = 0;
  int lat = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc          (id_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  // Memory contents: instr = 0x00B50533 + (addr << 12).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00B5_0533 + (a << 12);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: grant seen at negedge, data returned lat cycles after the next edge.
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = '0;
  int          pend_w = 0;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_v && pend_w == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_a);
        pend_v      = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend_v) pend_w--;
      end
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        pend_v = 1'b1;
        pend_a = imem_addr;
        pend_w = lat;
      end
    end
  end

  // Monitor: every accepted decode transfer must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected none", id_pc, id_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("id_pc", id_pc, mon_e.pc);
        check("id_instr", id_instr, mon_e.instr);
        check("id_opcode", {25'b0, id_opcode}, {25'b0, mon_e.instr[6:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
`endif
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 0;
    @(negedge clk);
    check_reset_outputs();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [31:0] a);
    bit got;
    got = 1'b0;
    a   = 32'hFFFF_FFFF;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        got = 1'b1;
        a   = imem_addr;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected one within 60 cycles");
    end
  endtask

  task automatic wait_empty();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int n;

    // Streaming fetch, 1 cycle latency, decode always ready.
    do_reset();
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    exp_q.push_back('{instr: 32'h00B5_0533, pc: 32'h0});
    exp_q.push_back('{instr: 32'h00B5_4533, pc: 32'h4});
    exp_q.push_back('{instr: 32'h00B5_8533, pc: 32'h8});
    wait_grant(a); check("t1_addr0", a, 32'h0);
    wait_grant(a); check("t1_addr1", a, 32'h4);
    wait_grant(a); check("t1_addr2", a, 32'h8);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Decode stalled: buffer fills to depth 2 then fetching stops.
    do_reset();
    imem_gnt = 1'b1;
    exp_q.push_back('{instr: 32'h00B5_0533, pc: 32'h0});
    exp_q.push_back('{instr: 32'h00B5_4533, pc: 32'h4});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) n++;
    end
    check("t2_grants_stalled", n, 2);
    check("t2_req_idle", {31'b0, imem_req}, 32'h0);
    check("t2_head_valid", {31'b0, id_valid}, 32'h1);
    check("t2_head_pc", id_pc, 32'h0);
    step();
    id_ready = 1'b1;
    exp_q.push_back('{instr: 32'h00B5_8533, pc: 32'h8});
    wait_grant(a); check("t2_resume_addr", a, 32'h8);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Redirect in WAIT before data: the late word is drained.
    do_reset();
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    lat = 1;
    wait_grant(a); check("t3_addr0", a, 32'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    lat            = 0;
    step();
    redirect_valid = 1'b0;
    exp_q.push_back('{instr: 32'h00C5_0533, pc: 32'h100});
    wait_grant(a); check("t3_redirect_addr", a, 32'h100);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Redirect together with a pop and an rvalid push.
    do_reset();
    imem_gnt = 1'b1;
    exp_q.push_back('{instr: 32'h00B5_0533, pc: 32'h0});
    wait_grant(a); check("t4_addr0", a, 32'h0);
    wait_grant(a); check("t4_addr1", a, 32'h4);
    step();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_flushed_valid", {31'b0, id_valid}, 32'h0);
    exp_q.push_back('{instr: 32'h00E5_0533, pc: 32'h300});
    wait_grant(a); check("t4_redirect_addr", a, 32'h300);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // PC wrap at the top of the address space.
    do_reset();
    imem_gnt       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    exp_q.push_back('{instr: 32'h00B4_C533, pc: 32'hFFFF_FFFC});
    exp_q.push_back('{instr: 32'h00B5_0533, pc: 32'h0});
    wait_grant(a); check("t5_addr_top", a, 32'hFFFF_FFFC);
    wait_grant(a); check("t5_addr_wrap", a, 32'h0);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Redirect in REQ without grant withdraws the request.
    do_reset();
    id_ready = 1'b1;
    step();
    @(negedge clk);
    check("t6_req_held", {31'b0, imem_req}, 32'h1);
    check("t6_req_addr", imem_addr, 32'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t6_req_dropped", {31'b0, imem_req}, 32'h0);
    step();
    imem_gnt = 1'b1;
    exp_q.push_back('{instr: 32'h00F5_0533, pc: 32'h400});
    wait_grant(a); check("t6_redirect_addr", a, 32'h400);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Redirect in REQ with grant: the granted word is drained.
    do_reset();
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    step();
    redirect_valid = 1'b0;
    exp_q.push_back('{instr: 32'h0105_0533, pc: 32'h500});
    wait_grant(a); check("t7_redirect_addr", a, 32'h500);
    step(); imem_gnt = 1'b0;
    wait_empty();

    // Reset during WAIT; the stale response arrives after release.
    do_reset();
    imem_gnt = 1'b1;
    wait_grant(a); check("t8_addr0", a, 32'h0);
    step();
    lat = 2;
    wait_grant(a); check("t8_addr1", a, 32'h4);
    check("t8_pre_valid", {31'b0, id_valid}, 32'h1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    step();
    reset    = 1'b0;
    id_ready = 1'b1;
    lat      = 0;
    exp_q.push_back('{instr: 32'h00B5_0533, pc: 32'h0});
    wait_grant(a); check("t8_first_addr", a, 32'h0);
    step(); imem_gnt = 1'b0;
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
